victim_cache_ctrl: RTL and testbench
====================================

// Module: victim_cache_ctrl
// PURPOSE
//  Sequences the victim cache write side for the L1.5. Buffers evicted lines from the L1.5 pipeline
//  in a small FIFO and drains them one per cycle into the victim cache store/evict port.
//  Runs a flush FSM that invalidates every victim-cache entry by index.
//  Reports S1 reads that hit a line still in the buffer, so the L1.5 never misses an in-flight victim.
// PARAMETERS
//  ADDR_W      36   victim address width (L1.5 tag + index)
//  LINE_W      128  cacheline width
//  NUM_ENTRIES 16   victim cache entries (flush walk length)
//  IDX_W       4    log2(NUM_ENTRIES)
//  BUF_DEPTH   2    eviction buffer entries (>=1)
// PORTS
//  clk                       in   1       clock
//  rst                       in   1       synchronous, active-high reset
//  l15_vcc_evict_val         in   1       eviction line offered
//  vcc_l15_evict_rdy         out  1       eviction accepted when val&rdy
//  l15_vcc_evict_addr        in   ADDR_W  evicted line address
//  l15_vcc_evict_data        in   LINE_W  evicted line data
//  l15_vcc_flush_req         in   1       request full victim-cache invalidate
//  vcc_l15_flush_done        out  1       one-cycle pulse: flush complete
//  vcc_l15_busy              out  1       state != IDLE
//  l15_vcc_read_val_s1       in   1       L1.5 S1 victim lookup
//  l15_vcc_read_addr_s1      in   ADDR_W  S1 lookup address
//  vcc_l15_buf_hit_s2        out  1       S2: lookup matched a buffered line
//  vcc_l15_buf_data_s2       out  LINE_W  S2: matched line data (0 on miss)
//  vcc_vc_store_evict_val    out  1       write to victim cache this cycle
//  vcc_vc_store_evict_addr   out  ADDR_W  write address
//  vcc_vc_store_evict_data   out  LINE_W  write data
//  vcc_vc_inval_val          out  1       invalidate victim-cache entry
//  vcc_vc_inval_index        out  IDX_W   entry to invalidate
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, flush index 0. All outputs 0, including rdy and the S2 regs.
//  - rdy = (count < BUF_DEPTH) && state==IDLE. rdy has no combinational path from val.
//    There is no push/pop bypass at full.
//  - Drain: store_evict_* are registered from the FIFO head. The val&rdy accept in cycle t gives
//    store_evict_val at t+1 at the earliest when the FIFO is empty. The write pops at most one
//    entry per cycle, in FIFO order. Draining runs in IDLE and DRAIN.
//  - Push and pop may occur in the same cycle. Count stays unchanged. Pointers wrap modulo BUF_DEPTH.
//  - Lookup: read_addr_s1 is compared against every valid FIFO entry, including the head being
//    written this cycle. The youngest match wins. hit/data are registered into S2 (1-cycle latency).
//    Without read_val_s1 the S2 regs are 0 the next cycle.
//  - FSM:
//    IDLE  -> DRAIN when flush_req=1; an eviction accepted in the same cycle still drains first.
//    DRAIN -> FLUSH when the FIFO is empty and no write is outstanding.
//    FLUSH: inval_val=1, inval_index = 0..NUM_ENTRIES-1, one per cycle. No store_evict while in FLUSH.
//    FLUSH -> DONE after index NUM_ENTRIES-1 has issued.
//    DONE: flush_done=1 for one cycle, then -> IDLE.
//  - flush_req is ignored outside IDLE. If flush_req is still high in the cycle after DONE,
//    a new flush starts.
//  - inval and store_evict are never asserted in the same cycle.
//  - A reset mid-flush or mid-drain discards the buffered lines and aborts the walk.
//    The victim cache's own reset covers consistency.
// STRUCTURE
//  - Shared defines: VC_ADDR_WIDTH, VC_NUM_ENTRIES, VC_NUM_ENTRIES_LOG2, L15_CACHELINE_WIDTH,
//    and the VCC state encodings (IDLE=0, DRAIN=1, FLUSH=2, DONE=3).
//  - Sub-module vcc_evict_fifo: storage, pointers, count, and the associative lookup port.
//    The FSM, output registers and S2 regs stay at the top level.
// TESTING
//  - Reset, then one evict at addr 0x1_0000_0040 with data 0xA5..:
//    rdy=1, store_evict_val=1 the next cycle with the same addr/data, FIFO empty after.
//  - 3 back-to-back evicts with BUF_DEPTH=2 and no drain stall: rdy never drops, or drops for at
//    most one cycle. Writes appear in order A, B, C with no loss or duplication.
//  - Evict X, then S1 read of X in the following cycle while X is the head: buf_hit_s2=1 with X's
//    data. A read of addr Y not buffered gives hit=0 and data=0.
//  - Two entries buffered, then flush_req pulse: both are written first; then inval_index
//    0..15 on 16 consecutive cycles; flush_done for 1 cycle; rdy=0 throughout; busy high from the
//    cycle after the request until done.
//  - flush_req and evict_val asserted in the same IDLE cycle: the evict is accepted and written
//    before inval_index 0. flush_req held high triggers a second full walk after DONE.
//  - rst asserted at inval_index 7: the next cycle shows state IDLE, all outputs 0 and rdy 0;
//    rdy returns to 1 after rst deasserts.

Source files
------------

// File: rtl/victim_cache_ctrl_pkg.sv
// rtl/victim_cache_ctrl_pkg.sv - shared widths and state encodings for the victim cache controller
package victim_cache_ctrl_pkg;

    localparam int VC_ADDR_WIDTH       = 36;
    localparam int VC_NUM_ENTRIES      = 16;
    localparam int VC_NUM_ENTRIES_LOG2 = 4;
    localparam int L15_CACHELINE_WIDTH = 128;

    typedef enum logic [1:0] {
        VCC_STATE_IDLE  = 2'd0,
        VCC_STATE_DRAIN = 2'd1,
        VCC_STATE_FLUSH = 2'd2,
        VCC_STATE_DONE  = 2'd3
    } vcc_state_t;

endpackage

// File: rtl/vcc_evict_fifo.sv
// rtl/vcc_evict_fifo.sv - eviction buffer with associative youngest-match lookup
module vcc_evict_fifo
    import victim_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = VC_ADDR_WIDTH,
    parameter int LINE_W = L15_CACHELINE_WIDTH,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [LINE_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // slot holding the entry that is 'age' positions younger than the head
    function automatic logic [PTR_W-1:0] age_slot(input logic [PTR_W-1:0] base, input int age);
        return PTR_W'((int'(base) + age) % DEPTH);
    endfunction

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // line storage; contents are only meaningful under count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // walk oldest to youngest so the youngest valid match overrides older ones
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && addr_mem[age_slot(rd_ptr, i)] == lookup_addr) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[age_slot(rd_ptr, i)];
            end
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - victim cache write sequencer: eviction drain, flush walk, S1 buffer lookup
module victim_cache_ctrl
    import victim_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W      = VC_ADDR_WIDTH,
    parameter int LINE_W      = L15_CACHELINE_WIDTH,
    parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
    parameter int IDX_W       = VC_NUM_ENTRIES_LOG2,
    parameter int BUF_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l15_vcc_evict_val,
    output logic              vcc_l15_evict_rdy,
    input  logic [ADDR_W-1:0] l15_vcc_evict_addr,
    input  logic [LINE_W-1:0] l15_vcc_evict_data,
    input  logic              l15_vcc_flush_req,
    output logic              vcc_l15_flush_done,
    output logic              vcc_l15_busy,
    input  logic              l15_vcc_read_val_s1,
    input  logic [ADDR_W-1:0] l15_vcc_read_addr_s1,
    output logic              vcc_l15_buf_hit_s2,
    output logic [LINE_W-1:0] vcc_l15_buf_data_s2,
    output logic              vcc_vc_store_evict_val,
    output logic [ADDR_W-1:0] vcc_vc_store_evict_addr,
    output logic [LINE_W-1:0] vcc_vc_store_evict_data,
    output logic              vcc_vc_inval_val,
    output logic [IDX_W-1:0]  vcc_vc_inval_index
);

    localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);

    vcc_state_t        state;
    logic [IDX_W-1:0]  flush_idx;
    logic              rdy_q;
    logic              busy_q;
    logic              inval_q;
    logic              done_q;

    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] head_addr;
    logic [LINE_W-1:0] head_data;
    logic              lk_hit;
    logic [LINE_W-1:0] lk_data;

    // the head is written while it is still buffered, so lookups see it until the pop lands
    assign push = l15_vcc_evict_val && rdy_q;
    assign pop  = (fifo_count != '0) &&
                  (state == VCC_STATE_IDLE || state == VCC_STATE_DRAIN);

    vcc_evict_fifo #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (BUF_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (l15_vcc_evict_addr),
        .push_data   (l15_vcc_evict_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (fifo_count),
        .lookup_addr (l15_vcc_read_addr_s1),
        .lookup_hit  (lk_hit),
        .lookup_data (lk_data)
    );

    // occupancy after this cycle's push/pop, used to register rdy without a path from val
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)      count_nxt = fifo_count + CNT_W'(1);
        else if (!push && pop) count_nxt = fifo_count - CNT_W'(1);
    end

    // flush sequencer: drain buffer, walk every index, pulse done; rdy/busy/inval registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= VCC_STATE_IDLE;
            flush_idx <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            inval_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rdy_q   <= 1'b0;
            inval_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                VCC_STATE_IDLE: begin
                    if (l15_vcc_flush_req) begin
                        state  <= VCC_STATE_DRAIN;
                        busy_q <= 1'b1;
                    end else begin
                        rdy_q <= (count_nxt < DEPTH_C);
                    end
                end
                VCC_STATE_DRAIN: begin
                    if (fifo_count == '0) begin
                        state     <= VCC_STATE_FLUSH;
                        flush_idx <= '0;
                        inval_q   <= 1'b1;
                    end
                end
                VCC_STATE_FLUSH: begin
                    if (flush_idx == LAST_IDX) begin
                        state  <= VCC_STATE_DONE;
                        done_q <= 1'b1;
                    end else begin
                        flush_idx <= flush_idx + IDX_W'(1);
                        inval_q   <= 1'b1;
                    end
                end
                VCC_STATE_DONE: begin
                    state     <= VCC_STATE_IDLE;
                    busy_q    <= 1'b0;
                    flush_idx <= '0;
                    rdy_q     <= (count_nxt < DEPTH_C);
                end
                default: state <= VCC_STATE_IDLE;
            endcase
        end
    end

    // S2 lookup result; a cycle without a lookup clears both regs
    always_ff @(posedge clk) begin
        if (rst || !l15_vcc_read_val_s1) begin
            vcc_l15_buf_hit_s2  <= 1'b0;
            vcc_l15_buf_data_s2 <= '0;
        end else begin
            vcc_l15_buf_hit_s2  <= lk_hit;
            vcc_l15_buf_data_s2 <= lk_hit ? lk_data : '0;
        end
    end

    assign vcc_l15_evict_rdy       = rdy_q;
    assign vcc_l15_busy            = busy_q;
    assign vcc_l15_flush_done      = done_q;
    assign vcc_vc_inval_val        = inval_q;
    assign vcc_vc_inval_index      = inval_q ? flush_idx : '0;
    assign vcc_vc_store_evict_val  = pop;
    assign vcc_vc_store_evict_addr = pop ? head_addr : '0;
    assign vcc_vc_store_evict_data = pop ? head_data : '0;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb/tb_victim_cache_ctrl.sv - directed self-checking bench for victim_cache_ctrl
module tb_victim_cache_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          l15_vcc_evict_val = 1'b0;
    logic          vcc_l15_evict_rdy;
    logic [35:0]   l15_vcc_evict_addr = '0;
    logic [127:0]  l15_vcc_evict_data = '0;
    logic          l15_vcc_flush_req = 1'b0;
    logic          vcc_l15_flush_done;
    logic          vcc_l15_busy;
    logic          l15_vcc_read_val_s1 = 1'b0;
    logic [35:0]   l15_vcc_read_addr_s1 = '0;
    logic          vcc_l15_buf_hit_s2;
    logic [127:0]  vcc_l15_buf_data_s2;
    logic          vcc_vc_store_evict_val;
    logic [35:0]   vcc_vc_store_evict_addr;
    logic [127:0]  vcc_vc_store_evict_data;
    logic          vcc_vc_inval_val;
    logic [3:0]    vcc_vc_inval_index;

    int n_cmp = 0;
    int n_bad = 0;

    logic [35:0]  exp_addr [$];
    logic [127:0] exp_data [$];

    always #5 clk = ~clk;

    victim_cache_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .l15_vcc_evict_val       (l15_vcc_evict_val),
        .vcc_l15_evict_rdy       (vcc_l15_evict_rdy),
        .l15_vcc_evict_addr      (l15_vcc_evict_addr),
        .l15_vcc_evict_data      (l15_vcc_evict_data),
        .l15_vcc_flush_req       (l15_vcc_flush_req),
        .vcc_l15_flush_done      (vcc_l15_flush_done),
        .vcc_l15_busy            (vcc_l15_busy),
        .l15_vcc_read_val_s1     (l15_vcc_read_val_s1),
        .l15_vcc_read_addr_s1    (l15_vcc_read_addr_s1),
        .vcc_l15_buf_hit_s2      (vcc_l15_buf_hit_s2),
        .vcc_l15_buf_data_s2     (vcc_l15_buf_data_s2),
        .vcc_vc_store_evict_val  (vcc_vc_store_evict_val),
        .vcc_vc_store_evict_addr (vcc_vc_store_evict_addr),
        .vcc_vc_store_evict_data (vcc_vc_store_evict_data),
        .vcc_vc_inval_val        (vcc_vc_inval_val),
        .vcc_vc_inval_index      (vcc_vc_inval_index)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] data_of(input logic [35:0] a);
        return {a[31:0], ~a[31:0], a[31:0], ~a[31:0]};
    endfunction

    // offer one line this cycle; the caller ticks. Records it if rdy says it will be taken.
    task automatic offer(input logic [35:0] a);
        l15_vcc_evict_val  = 1'b1;
        l15_vcc_evict_addr = a;
        l15_vcc_evict_data = data_of(a);
        if (vcc_l15_evict_rdy) begin
            exp_addr.push_back(a);
            exp_data.push_back(data_of(a));
        end
    endtask

    task automatic take_store(input string tag);
        if (exp_addr.size() == 0) begin
            check({tag, " unexpected store"}, vcc_vc_store_evict_val, 1'b0);
        end else begin
            check({tag, " store addr"}, vcc_vc_store_evict_addr, exp_addr.pop_front());
            check({tag, " store data"}, vcc_vc_store_evict_data, exp_data.pop_front());
        end
    endtask

    // observe from the current cycle until flush_done, then check the walk as a whole
    task automatic watch_flush(input string tag, input bit hold_req, input int exp_writes);
        int cyc = 0;
        int writes = 0;
        int invals = 0;
        int dones = 0;
        int busy_rise = -1;
        bit seq_ok = 1'b1;
        bit overlap = 1'b0;
        bit rdy_busy = 1'b0;
        bit late_store = 1'b0;
        while (dones == 0 && cyc < 200) begin
            if (vcc_vc_store_evict_val) begin
                if (invals > 0) late_store = 1'b1;
                writes++;
                take_store(tag);
            end
            if (vcc_vc_inval_val) begin
                if (int'(vcc_vc_inval_index) != invals) seq_ok = 1'b0;
                invals++;
            end else if (invals > 0 && invals < 16) begin
                seq_ok = 1'b0;
            end
            if (vcc_vc_store_evict_val && vcc_vc_inval_val) overlap = 1'b1;
            if (vcc_l15_busy && vcc_l15_evict_rdy) rdy_busy = 1'b1;
            if (vcc_l15_busy && busy_rise < 0) busy_rise = cyc;
            if (vcc_l15_flush_done) dones++;
            tick();
            cyc++;
            if (cyc == 1) begin
                l15_vcc_evict_val = 1'b0;
                l15_vcc_flush_req = hold_req;
            end
        end
        check({tag, " done seen"}, dones, 1);
        check({tag, " writes before walk"}, writes, exp_writes);
        check({tag, " inval count"}, invals, 16);
        check({tag, " inval index sequence"}, seq_ok, 1'b1);
        check({tag, " store during walk"}, late_store, 1'b0);
        check({tag, " store+inval overlap"}, overlap, 1'b0);
        check({tag, " rdy while busy"}, rdy_busy, 1'b0);
        check({tag, " busy rise cycle"}, busy_rise, 1);
        check({tag, " done one cycle"}, vcc_l15_flush_done, 1'b0);
        check({tag, " busy after done"}, vcc_l15_busy, 1'b0);
    endtask

    initial begin
        logic [35:0] b2b [3] = '{36'h0_0000_1000, 36'h0_0000_2040, 36'h0_0000_3080};
        int k;
        int low;
        int written;
        int w;

        // reset state
        tick();
        tick();
        check("rst rdy", vcc_l15_evict_rdy, 1'b0);
        check("rst store_val", vcc_vc_store_evict_val, 1'b0);
        check("rst store_addr", vcc_vc_store_evict_addr, 36'h0);
        check("rst busy", vcc_l15_busy, 1'b0);
        check("rst done", vcc_l15_flush_done, 1'b0);
        check("rst inval", vcc_vc_inval_val, 1'b0);
        check("rst hit", vcc_l15_buf_hit_s2, 1'b0);
        check("rst buf data", vcc_l15_buf_data_s2, 128'h0);
        rst = 1'b0;
        tick();
        check("rdy after reset", vcc_l15_evict_rdy, 1'b1);

        // single eviction, written the next cycle, buffer empty afterwards
        l15_vcc_evict_val  = 1'b1;
        l15_vcc_evict_addr = 36'h1_0000_0040;
        l15_vcc_evict_data = {16{8'hA5}};
        tick();
        l15_vcc_evict_val = 1'b0;
        check("single store_val", vcc_vc_store_evict_val, 1'b1);
        check("single store_addr", vcc_vc_store_evict_addr, 36'h1_0000_0040);
        check("single store_data", vcc_vc_store_evict_data, {16{8'hA5}});
        tick();
        check("single drained", vcc_vc_store_evict_val, 1'b0);
        check("single rdy", vcc_l15_evict_rdy, 1'b1);

        // three back-to-back evictions drain in order
        k = 0;
        low = 0;
        written = 0;
        for (int c = 0; c < 10; c++) begin
            if (vcc_vc_store_evict_val) begin
                take_store("b2b");
                written++;
            end
            if (k < 3) begin
                if (!vcc_l15_evict_rdy) low++;
                offer(b2b[k]);
                if (vcc_l15_evict_rdy) k++;
            end else begin
                l15_vcc_evict_val = 1'b0;
            end
            tick();
        end
        check("b2b written", written, 3);
        check("b2b rdy low cycles", low <= 1, 1'b1);
        check("b2b queue empty", exp_addr.size(), 0);

        // lookup hits the in-flight head, misses an unbuffered address
        offer(36'h4_5678_9AC0);
        tick();
        l15_vcc_evict_val    = 1'b0;
        take_store("lookup");
        l15_vcc_read_val_s1  = 1'b1;
        l15_vcc_read_addr_s1 = 36'h4_5678_9AC0;
        tick();
        check("lookup hit", vcc_l15_buf_hit_s2, 1'b1);
        check("lookup data", vcc_l15_buf_data_s2, data_of(36'h4_5678_9AC0));
        l15_vcc_read_addr_s1 = 36'h9_9999_9980;
        tick();
        check("lookup miss hit", vcc_l15_buf_hit_s2, 1'b0);
        check("lookup miss data", vcc_l15_buf_data_s2, 128'h0);
        l15_vcc_read_val_s1  = 1'b0;
        l15_vcc_read_addr_s1 = 36'h4_5678_9AC0;
        tick();
        check("no lookup hit", vcc_l15_buf_hit_s2, 1'b0);

        // two buffered lines then a flush pulse
        offer(36'h0_0000_5000);
        check("flush1 rdy e1", vcc_l15_evict_rdy, 1'b1);
        tick();
        offer(36'h0_0000_6000);
        check("flush1 rdy e2", vcc_l15_evict_rdy, 1'b1);
        l15_vcc_flush_req = 1'b1;
        watch_flush("flush1", 1'b0, 2);

        // evict with flush in the same cycle; flush held for a second walk
        offer(36'h2_0000_7000);
        check("flush2 rdy", vcc_l15_evict_rdy, 1'b1);
        l15_vcc_flush_req = 1'b1;
        watch_flush("flush2", 1'b1, 1);
        watch_flush("flush3", 1'b0, 0);
        check("queue empty after flushes", exp_addr.size(), 0);

        // reset in the middle of the walk
        l15_vcc_flush_req = 1'b1;
        tick();
        l15_vcc_flush_req = 1'b0;
        w = 0;
        while (!(vcc_vc_inval_val && vcc_vc_inval_index == 4'd7) && w < 100) begin
            tick();
            w++;
        end
        check("reached index 7", w < 100, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst busy", vcc_l15_busy, 1'b0);
        check("midrst inval", vcc_vc_inval_val, 1'b0);
        check("midrst inval index", vcc_vc_inval_index, 4'd0);
        check("midrst rdy", vcc_l15_evict_rdy, 1'b0);
        check("midrst store", vcc_vc_store_evict_val, 1'b0);
        check("midrst done", vcc_l15_flush_done, 1'b0);
        rst = 1'b0;
        tick();
        check("rdy after midrst", vcc_l15_evict_rdy, 1'b1);
        check("busy after midrst", vcc_l15_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
